alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 132 +++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared combinational ALU: arbitrates, registers
// operands, captures the result one cycle later and holds it until accepted.
module alu_arbiter #(
  parameter int unsigned RR_EN = 1
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] a0,
  input  logic [31:0] a1,
  input  logic [31:0] b0,
  input  logic [31:0] b1,
  input  logic [3:0]  aluc0,
  input  logic [3:0]  aluc1,
  output logic        gnt0,
  output logic        gnt1,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_aluc,
  input  logic [31:0] alu_s,
  input  logic        alu_z,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic        rsp_id,
  output logic [31:0] rsp_s,
  output logic        rsp_z,
  output logic        rsp_err,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_last;
  logic [31:0] r_alu_a;
  logic [31:0] r_alu_b;
  logic [3:0]  r_alu_aluc;
  logic        r_rsp_valid;
  logic        r_rsp_id;
  logic [31:0] r_rsp_s;
  logic        r_rsp_z;
  logic        r_rsp_err;
  logic        w_pick1;
  logic        w_gnt0;
  logic        w_gnt1;
  logic        w_illegal;

  // Requester 1 wins when alone, or on a tie only in round-robin mode after a grant to 0.
  always_comb begin
    w_pick1 = req1 && (!req0 || ((RR_EN != 0) && !r_last));
    w_gnt0  = 1'b0;
    w_gnt1  = 1'b0;
    w_next  = r_state;
    case (r_state)
      IDLE: begin
        w_gnt0 = resetn && req0 && !w_pick1;
        w_gnt1 = resetn && w_pick1;
        if (w_gnt0 || w_gnt1) w_next = EXEC;
      end
      EXEC: w_next = RESP;
      RESP: if (rsp_ready) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_comb begin
    w_illegal = 1'b1;
    case (r_alu_aluc)
      4'b0000, 4'b0100, 4'b0001, 4'b0101,
      4'b0010, 4'b0110, 4'b0011, 4'b0111, 4'b1111: w_illegal = 1'b0;
      default: w_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!resetn) r_state <= IDLE;
    else         r_state <= w_next;
  end

  always_ff @(posedge clock) begin
    if (!resetn) begin
      r_last      <= 1'b1;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_aluc  <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_id    <= 1'b0;
      r_rsp_s     <= '0;
      r_rsp_z     <= 1'b0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_gnt0 || w_gnt1) begin
            r_alu_a    <= w_gnt1 ? a1 : a0;
            r_alu_b    <= w_gnt1 ? b1 : b0;
            r_alu_aluc <= w_gnt1 ? aluc1 : aluc0;
            r_rsp_id   <= w_gnt1;
            r_last     <= w_gnt1;
          end
        end
        EXEC: begin
          r_rsp_valid <= 1'b1;
          r_rsp_err   <= w_illegal;
          r_rsp_s     <= w_illegal ? '0 : alu_s;
          r_rsp_z     <= w_illegal ? 1'b1 : alu_z;
        end
        RESP: if (rsp_ready) r_rsp_valid <= 1'b0;
        default: r_rsp_valid <= 1'b0;
      endcase
    end
  end

  assign gnt0      = w_gnt0;
  assign gnt1      = w_gnt1;
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_aluc  = r_alu_aluc;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_s     = r_rsp_s;
  assign rsp_z     = r_rsp_z;
  assign rsp_err   = r_rsp_err;
  assign busy      = (r_state != IDLE);

endmodule
